// File: rtl/dmem_responder_pkg.sv
// Shared FSM state type, RISC-V load/store funct3 codes and the request legality rule.
package Pipe_Buf_Reg_PKG;

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants exist only for loads; halfwords and words must be naturally aligned.
   function automatic logic req_legal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane extract/extend for loads and lane merge for stores on one little-endian word.
module dmem_lane_unit
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merged
);

   logic [4:0]        shamt;
   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] mask;
   logic              sign;

   always_comb begin
      shamt = {addr_lo, 3'b000};
      lane  = word >> shamt;
      case (funct3[1:0])
         2'b00: begin
            mask = DATA_W'(8'hFF);
            sign = lane[7];
         end
         2'b01: begin
            mask = DATA_W'(16'hFFFF);
            sign = lane[15];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
      // funct3[2] marks the zero-extending load variants
      load_data = (lane & mask) | ((sign & ~funct3[2]) ? ~mask : '0);
      merged    = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
   end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding request, block-RAM word array.
module dmem_responder
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

   state_t                  state;
   logic                    lat_we;
   logic [DM_ADDRESS-1:0]   lat_addr;
   logic [DATA_W-1:0]       lat_wdata;
   logic [2:0]              lat_f3;
   logic                    rsp_load;
   logic [DATA_W-1:0]       rd_word;
   logic [DATA_W-1:0]       load_data;
   logic [DATA_W-1:0]       merged;
   logic [DM_ADDRESS-3:0]   idx;
   logic [DATA_W-1:0]       mem [DEPTH];

   assign idx = lat_addr[DM_ADDRESS-1:2];

   dmem_lane_unit #(.DATA_W(DATA_W)) u_lane (
      .funct3    (lat_f3),
      .addr_lo   (lat_addr[1:0]),
      .word      (rd_word),
      .wdata     (lat_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // Array has no reset; an asynchronous reset in WRITE leaves state != WRITE at the edge.
   always_ff @(posedge clk) begin
      if (state == WRITE)  mem[idx] <= merged;
      if (state == ACCESS) rd_word  <= mem[idx];
   end

   // rd_word is only refreshed in ACCESS, so the extended value holds through RESP.
   assign rsp_rdata = rsp_load ? load_data : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_load  <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_f3    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_f3    <= req_funct3;
                  req_ready <= 1'b0;
                  if (req_legal(req_we, req_funct3, req_addr[1:0])) begin
                     state <= ACCESS;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (lat_we) begin
                  state <= WRITE;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_load  <= 1'b1;
               end
            end
            WRITE: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_load  <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have one clock and reset: clk, active-high asynchronous reset named reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  DM_ADDRESS  byte address.
REQ-010 req_wdata  input  DATA_W  store data, right-aligned.
REQ-011 req_funct3  input  3  access size and sign (RISC-V funct3).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts response.
REQ-014 rsp_rdata  output  DATA_W  load result, extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned access or illegal funct3.

Function
REQ-016 SHALL hold a 2^(DM_ADDRESS-2) x DATA_W word array (128 words at default), little-endian byte lanes, indexed by req_addr[DM_ADDRESS-1:2].
REQ-017 SHALL accept a request on a rising edge only when req_valid and req_ready are both 1; it latches we/addr/wdata/funct3 on that edge.
REQ-018 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready is 1 only in IDLE.
REQ-019 IDLE: on accept, legal request -> ACCESS; illegal request -> RESP with rsp_err=1.
REQ-020 ACCESS: register array word at latched index; load -> RESP, store -> WRITE.
REQ-021 WRITE: write merged word (registered word with the selected lanes replaced) to the array on the edge leaving WRITE -> RESP.
REQ-022 RESP: rsp_valid=1; rsp_rdata/rsp_err stable until the edge with rsp_ready=1, then -> IDLE.
REQ-023 Latency from accept edge to rsp_valid: load 2 cycles, store 3 cycles, error 1 cycle.
REQ-024 Loads: 000 LB, 001 LH sign-extend; 100 LBU, 101 LHU zero-extend; 010 LW full word.
REQ-025 Stores: 000 SB uses wdata[7:0], 001 SH uses wdata[15:0], 010 SW uses full word; lanes outside the access are preserved.
REQ-026 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> rsp_err=1, no array write.
REQ-027 Illegal funct3: loads 011/110/111, stores other than 000/001/010 -> rsp_err=1, no array write.
REQ-028 SHALL ignore req_valid outside IDLE; no request queue; back-to-back requests accepted on the edge after the RESP handshake at the earliest.
REQ-029 rsp_rdata SHALL be 0 whenever rsp_valid=0.

Reset
REQ-030 While reset=1: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request cleared.
REQ-031 Reset SHALL NOT clear the word array.
REQ-032 Reset asserted in WRITE before the write edge SHALL abort the write; the word stays unchanged.
REQ-033 Reset asserted in RESP SHALL drop the pending response.

Structure
REQ-034 FSM state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) SHALL live in shared package Pipe_Buf_Reg_PKG.
REQ-035 Lane select/extract/extend and store merge SHALL be one combinational sub-module, dmem_lane_unit.
REQ-036 Array SHALL be a synchronous-write, registered-read memory only, for block-RAM inference.

Verification
REQ-037 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 3 cycles after store accept, 2 after load accept.
REQ-038 Word @0x010 = 0x11223344; SB 0x7F @0x013 -> LW @0x010 returns 0x7F223344; LB @0x013 returns 0x0000007F.
REQ-039 SB 0x80 @0x020; LB @0x020 -> 0xFFFFFF80; LBU @0x020 -> 0x00000080; SH 0x8001 @0x022 then LH @0x022 -> 0xFFFF8001, LHU -> 0x00008001.
REQ-040 LH @0x001 and SW @0x016 -> rsp_err=1 one cycle after accept, rsp_rdata=0; word @0x014 unchanged.
REQ-041 Hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0; req_valid pulses ignored.
REQ-042 Assert reset during WRITE of SW 0xCAFEF00D @0x040 (prior 0x0) -> outputs reset immediately; later LW @0x040 returns 0x00000000.
